// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the shared-multiplier scheduler.
// The shadow-entry id is sized for the largest requester count so one struct serves every configuration.
package mult_sched_pkg;

    localparam int unsigned MAX_NREQ  = 8;
    localparam int unsigned ID_W      = $clog2(MAX_NREQ);
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mult_op_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            hi;
    } shadow_entry_t;

    // Widens a width-bit value (right-aligned in value) to width+1 bits; bits above width stay zero.
    function automatic logic [MAX_WIDTH:0] ext_operand(
        input logic [MAX_WIDTH-1:0] value,
        input int unsigned          width,
        input logic                 is_signed
    );
        logic sign_bit;
        sign_bit = is_signed & (|(value & (MAX_WIDTH'(1) << (width - 1))));
        return {1'b0, value} | ({(MAX_WIDTH + 1){sign_bit}} & ((MAX_WIDTH + 1)'(1) << width));
    endfunction

endpackage

// File: rtl/mult_sched_if.sv
// Requester-side bundle of the multiplier scheduler: issue handshake plus shared response bus.
interface mult_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) ();

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*2-1:0]     req_op;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_result;

    modport master (
        output req_valid, req_a, req_b, req_op,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        output req_ready, rsp_valid, rsp_result
    );

endinterface

// File: rtl/mult_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr (cyclically) wins.
// Shared by the shared-unit schedulers; at most one grant bit is set.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_id,
    output logic          any
);

    logic [N-1:0]  rotated;
    logic [PW-1:0] offset;
    logic [PW:0]   id_sum;

    // Rotate so that bit 0 is the requester at ptr.
    assign rotated = N'({req, req} >> ptr);
    assign any     = |rotated;

    always_comb begin
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = PW'(k);
            end
        end
    end

    always_comb begin
        id_sum = {1'b0, ptr} + {1'b0, offset};
        if (id_sum >= (PW + 1)'(N)) begin
            grant_id = PW'(id_sum - (PW + 1)'(N));
        end else begin
            grant_id = id_sum[PW-1:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = any && (grant_id == PW'(gi));
        end
    endgenerate

endmodule

// File: rtl/mult_sched.sv
// Shares one pipelined signed multiplier among NREQ requesters, mapping MUL/MULH/MULHSU/MULHU onto it
// and steering each result back to its issuer through a shadow pipeline that mirrors the multiplier.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    mult_sched_if.slave        bus,
    output logic [WIDTH:0]     mult_dataa,
    output logic [WIDTH:0]     mult_datab,
    output logic               mult_clken,
    output logic               mult_sclr,
    input  logic [2*WIDTH+1:0] mult_result
);

    localparam int PW = $clog2(NREQ);

    logic [WIDTH-1:0] a_arr  [NREQ];
    logic [WIDTH-1:0] b_arr  [NREQ];
    mult_op_t         op_arr [NREQ];

    logic [NREQ-1:0]  busy_reg, busy_next;
    logic [PW-1:0]    rr_ptr_reg;
    logic [NREQ-1:0]  rsp_valid_reg;
    logic [WIDTH-1:0] rsp_result_reg;
    shadow_entry_t    shadow_reg [LATENCY];

    logic [NREQ-1:0]  arb_grant;
    logic [PW-1:0]    arb_id;
    logic             arb_any;
    logic             grant_en;
    mult_op_t         grant_op;
    shadow_entry_t    stage0_in;
    shadow_entry_t    last_stage;
    logic [NREQ-1:0]  retire_vec;
    logic [WIDTH-1:0] result_sel;
    logic             unused_mult_top;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi]  = bus.req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]  = bus.req_b[gi*WIDTH +: WIDTH];
            assign op_arr[gi] = mult_op_t'(bus.req_op[gi*2 +: 2]);
        end
    endgenerate

    rr_arbiter #(.N(NREQ)) u_arb (
        .req      (bus.req_valid & ~busy_reg),
        .ptr      (rr_ptr_reg),
        .grant    (arb_grant),
        .grant_id (arb_id),
        .any      (arb_any)
    );

    // Nothing is granted while reset is held, so the multiplier sees zeros then.
    assign grant_en      = arb_any & reset_n;
    assign bus.req_ready = arb_grant & {NREQ{reset_n}};
    assign grant_op      = op_arr[arb_id];

    always_comb begin
        mult_dataa = '0;
        mult_datab = '0;
        stage0_in  = '0;
        if (grant_en) begin
            mult_dataa      = (WIDTH + 1)'(ext_operand(MAX_WIDTH'(a_arr[arb_id]), WIDTH,
                                                       grant_op != OP_MULHU));
            mult_datab      = (WIDTH + 1)'(ext_operand(MAX_WIDTH'(b_arr[arb_id]), WIDTH,
                                                       (grant_op == OP_MUL) || (grant_op == OP_MULH)));
            stage0_in.valid = 1'b1;
            stage0_in.id    = ID_W'(arb_id);
            stage0_in.hi    = (grant_op != OP_MUL);
        end
    end

    assign mult_clken = 1'b1;
    assign mult_sclr  = ~reset_n;

    // The shadow stages line up with the multiplier registers, so the last stage describes mult_result.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int s = 0; s < LATENCY; s++) begin
                shadow_reg[s] <= '0;
            end
        end else begin
            for (int s = LATENCY - 1; s > 0; s--) begin
                shadow_reg[s] <= shadow_reg[s-1];
            end
            shadow_reg[0] <= stage0_in;
        end
    end

    assign last_stage = shadow_reg[LATENCY-1];

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_retire
            assign retire_vec[gi] = last_stage.valid && (last_stage.id == ID_W'(gi));
        end
    endgenerate

    assign result_sel      = last_stage.hi ? mult_result[2*WIDTH-1:WIDTH] : mult_result[WIDTH-1:0];
    assign unused_mult_top = ^mult_result[2*WIDTH+1:2*WIDTH];
    // A retiring requester is free on the same edge that raises its rsp_valid.
    assign busy_next       = (busy_reg & ~retire_vec) | bus.req_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_reg       <= '0;
            rr_ptr_reg     <= '0;
            rsp_valid_reg  <= '0;
            rsp_result_reg <= '0;
        end else begin
            busy_reg      <= busy_next;
            rsp_valid_reg <= retire_vec;
            if (grant_en) begin
                rr_ptr_reg <= (arb_id == PW'(NREQ - 1)) ? '0 : PW'(arb_id + 1'b1);
            end
            if (last_stage.valid) begin
                rsp_result_reg <= result_sel;
            end
        end
    end

    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_result = rsp_result_reg;

endmodule

// File: tb/tb_mult_sched.sv
// Randomized and directed bench for mult_sched with a behavioural signed pipelined multiplier
// and a cycle-level reference model of arbitration, latency and RISC-V multiply results.
module tb_mult_sched;
    import mult_sched_pkg::*;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 32;
    localparam int LATENCY = 3;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic [WIDTH:0]     mult_dataa, mult_datab;
    logic               mult_clken, mult_sclr;
    logic [2*WIDTH+1:0] mult_result;

    mult_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    mult_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .mult_dataa  (mult_dataa),
        .mult_datab  (mult_datab),
        .mult_clken  (mult_clken),
        .mult_sclr   (mult_sclr),
        .mult_result (mult_result)
    );

    always #5 clock = ~clock;

    // Stand-in for a signed lpm_mult with lpm_pipeline = LATENCY.
    logic signed [2*WIDTH+1:0] mpipe [LATENCY];
    always @(posedge clock) begin
        if (mult_sclr) begin
            for (int s = 0; s < LATENCY; s++) mpipe[s] <= '0;
        end else if (mult_clken) begin
            mpipe[0] <= $signed(mult_dataa) * $signed(mult_datab);
            for (int s = 1; s < LATENCY; s++) mpipe[s] <= mpipe[s-1];
        end
    end
    assign mult_result = mpipe[LATENCY-1];

    typedef struct {
        int          due;
        int          id;
        logic [31:0] res;
    } pend_t;

    pend_t           pend_q[$];
    bit              model_busy [NREQ];
    int              model_ptr = 0;
    int              checks = 0, errors = 0, cyc = 0;
    int              rsp_count = 0, hs_count = 0;
    int              last_hs_cyc = -1, last_rsp_cyc = -1, last_rsp_id = -1, cycle_hs_id = -1;
    logic [31:0]     last_rsp_result = '0;
    logic            last_sclr = 1'b0;
    logic [NREQ-1:0] last_ready = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // RISC-V multiply semantics computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'd0:    begin sp = sa * sb;          return sp[31:0];  end
            2'd1:    begin sp = sa * sb;          return sp[63:32]; end
            2'd2:    begin sp = sa * longint'(ub); return sp[63:32]; end
            default: begin up = ua * ub;          return up[63:32]; end
        endcase
    endfunction

    task automatic set_req(input int id, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        bus.req_a[id*WIDTH +: WIDTH] = a;
        bus.req_b[id*WIDTH +: WIDTH] = b;
        bus.req_op[id*2 +: 2]        = op;
    endtask

    // One clock cycle: checks at the falling edge, then advances to just after the next rising edge.
    task automatic check_cycle();
        logic [NREQ-1:0] exp_rsp, exp_ready;
        logic [31:0]     exp_res, a, b;
        logic [1:0]      op;
        logic [32:0]     ea, eb;
        int              rid, del, g, idx;
        @(negedge clock);
        exp_rsp     = '0;
        exp_res     = '0;
        rid         = -1;
        del         = -1;
        cycle_hs_id = -1;
        foreach (pend_q[k]) begin
            if (rid < 0 && pend_q[k].due == cyc) begin
                rid = pend_q[k].id;
                exp_res = pend_q[k].res;
                del = k;
            end
        end
        if (del >= 0) begin
            pend_q.delete(del);
            exp_rsp = NREQ'(1) << rid;
        end
        check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
        if (rid >= 0) check_eq("rsp_result", 64'(bus.rsp_result), 64'(exp_res));
        if (bus.rsp_valid != '0) begin
            rsp_count++;
            last_rsp_cyc    = cyc;
            last_rsp_result = bus.rsp_result;
            for (int k = 0; k < NREQ; k++) if (bus.rsp_valid[k]) last_rsp_id = k;
            $display("cycle %0d: response to req%0d result 0x%08h", cyc, last_rsp_id, bus.rsp_result);
        end
        check_eq("mult_clken", 64'(mult_clken), 64'd1);
        last_sclr  = mult_sclr;
        last_ready = bus.req_ready;
        if (!reset_n) begin
            pend_q.delete();
            foreach (model_busy[k]) model_busy[k] = 1'b0;
            model_ptr = 0;
            check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
            check_eq("rst_sclr", 64'(mult_sclr), 64'd1);
            check_eq("rst_dataa", 64'(mult_dataa), 64'd0);
            check_eq("rst_datab", 64'(mult_datab), 64'd0);
        end else begin
            if (rid >= 0) model_busy[rid] = 1'b0;
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (model_ptr + k) % NREQ;
                if (g < 0 && bus.req_valid[idx] && !model_busy[idx]) g = idx;
            end
            exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
            check_eq("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            check_eq("mult_sclr", 64'(mult_sclr), 64'd0);
            if (g >= 0) begin
                op = bus.req_op[g*2 +: 2];
                a  = bus.req_a[g*WIDTH +: WIDTH];
                b  = bus.req_b[g*WIDTH +: WIDTH];
                ea = (op == 2'd3) ? {1'b0, a} : {a[31], a};
                eb = op[1] ? {1'b0, b} : {b[31], b};
                check_eq("mult_dataa", 64'(mult_dataa), 64'(ea));
                check_eq("mult_datab", 64'(mult_datab), 64'(eb));
                model_busy[g] = 1'b1;
                model_ptr     = (g + 1) % NREQ;
                pend_q.push_back('{cyc + LATENCY + 1, g, ref_result(op, a, b)});
                last_hs_cyc = cyc;
                cycle_hs_id = g;
                hs_count++;
            end else begin
                check_eq("idle_dataa", 64'(mult_dataa), 64'd0);
                check_eq("idle_datab", 64'(mult_datab), 64'd0);
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drain();
        bus.req_valid = '0;
        repeat (LATENCY + 3) check_cycle();
    endtask

    task automatic directed_op(input int id, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp, input string tag);
        int hs0, r0, n;
        set_req(id, op, a, b);
        bus.req_valid = NREQ'(1) << id;
        hs0 = hs_count;
        n   = 0;
        while (hs_count == hs0 && n < 8) begin check_cycle(); n++; end
        bus.req_valid = '0;
        check_eq({tag, "_grant"}, 64'(hs_count - hs0), 64'd1);
        if (hs_count == hs0) return;
        r0 = rsp_count;
        n  = 0;
        while (rsp_count == r0 && n < 10) begin check_cycle(); n++; end
        check_eq({tag, "_rsp"}, 64'(rsp_count - r0), 64'd1);
        if (rsp_count == r0) return;
        check_eq({tag, "_id"}, 64'(last_rsp_id), 64'(id));
        check_eq({tag, "_val"}, 64'(last_rsp_result), 64'(exp));
        check_eq({tag, "_lat"}, 64'(last_rsp_cyc - last_hs_cyc), 64'(LATENCY + 1));
    endtask

    initial begin
        int          r0, nib;
        logic [31:0] code;
        logic [5:0]  hist;
        logic [31:0] opnd [4];

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        reset_n       = 1'b0;
        @(posedge clock);
        #1;
        repeat (3) check_cycle();
        check_eq("reset_rsp_result", 64'(bus.rsp_result), 64'd0);
        reset_n = 1'b1;

        directed_op(0, 2'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7xm3");
        drain();
        directed_op(1, 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        directed_op(1, 2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulhu_min");
        directed_op(1, 2'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, "mulhsu_min");
        directed_op(1, 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "mul_min");
        drain();

        // A lone requester held valid: ready at T, blocked T+1..T+3, re-granted at T+4.
        set_req(2, 2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        bus.req_valid = 4'b0100;
        hist = '0;
        for (int k = 0; k < 6; k++) begin
            check_cycle();
            hist[k] = last_ready[2];
        end
        check_eq("busy_block", 64'(hist), 64'(6'b010001));
        drain();

        // All requesters valid from a fresh pointer: grants 0,1,2,3 then re-grants on response.
        reset_n = 1'b0;
        check_cycle();
        reset_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 2'($urandom_range(0, 3)), $urandom, $urandom);
        bus.req_valid = '1;
        code = '0;
        for (int k = 0; k < 8; k++) begin
            check_cycle();
            nib  = (cycle_hs_id < 0) ? 15 : cycle_hs_id;
            code = code | (32'(nib) << (4 * k));
        end
        check_eq("rr_order", 64'(code), 64'h3210_3210);
        drain();

        // Reset two cycles after an issue drops it; the requester is grantable right after.
        set_req(3, 2'd0, 32'd11, 32'd13);
        bus.req_valid = 4'b1000;
        r0 = rsp_count;
        check_cycle();
        check_eq("rst_issue", 64'(cycle_hs_id), 64'd3);
        check_cycle();
        reset_n = 1'b0;
        check_cycle();
        check_eq("rst_sclr_pulse", 64'(last_sclr), 64'd1);
        reset_n = 1'b1;
        check_cycle();
        check_eq("rst_regrant", 64'(cycle_hs_id), 64'd3);
        bus.req_valid = '0;
        repeat (3) check_cycle();
        check_eq("rst_dropped", 64'(rsp_count - r0), 64'd0);
        drain();

        r0 = rsp_count;
        bus.req_valid = '0;
        repeat (10) check_cycle();
        check_eq("idle_no_rsp", 64'(rsp_count - r0), 64'd0);

        opnd[0] = 32'h8000_0000;
        opnd[1] = 32'hFFFF_FFFF;
        opnd[2] = 32'h0000_0000;
        opnd[3] = 32'h7FFF_FFFF;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 2'($urandom_range(0, 3)),
                        ($urandom_range(0, 3) == 0) ? opnd[$urandom_range(0, 3)] : $urandom,
                        ($urandom_range(0, 3) == 0) ? opnd[$urandom_range(0, 3)] : $urandom);
            end
            bus.req_valid = NREQ'($urandom_range(0, 15));
            reset_n       = ($urandom_range(0, 199) != 0);
            check_cycle();
        end
        reset_n = 1'b1;
        drain();
        check_eq("queue_empty", 64'(pend_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_sched.md
# mult_sched

Shared-multiplier scheduler for the shader core. It arbitrates up to `NREQ` requesters (ALU lanes, address generation) onto one pipelined signed `lpm_mult` instance, and maps the RISC-V MUL/MULH/MULHSU/MULHU semantics onto that signed multiplier. It also tracks in-flight operations through the multiplier pipeline and steers each result back to its issuer. It sits between the lane issue logic and a single `lpm_mult` with `lpm_representation="SIGNED"`, `lpm_widtha=lpm_widthb=WIDTH+1`, `lpm_widthp=2*WIDTH+2`, and `lpm_pipeline=LATENCY`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand and result width.
- `LATENCY`, 3: multiplier pipeline depth in cycles, 1..8. It must equal the multiplier's `lpm_pipeline`.
- `clock` in 1: the single clock; all logic is on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in `NREQ`: request i is present.
- `req_ready` out `NREQ`: grant to requester i; a handshake is `req_valid[i] & req_ready[i]`.
- `req_a` in `NREQ*WIDTH`: operand A of requester i, at bits `[i*WIDTH +: WIDTH]`.
- `req_b` in `NREQ*WIDTH`: operand B of requester i, at the same slicing.
- `req_op` in `NREQ*2`: op of requester i: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
- `rsp_valid` out `NREQ`: one-hot or zero; a single-cycle result pulse to requester i.
- `rsp_result` out `WIDTH`: shared result bus, valid while any `rsp_valid` bit is set.
- `mult_dataa` out `WIDTH+1`: to multiplier `dataa`.
- `mult_datab` out `WIDTH+1`: to multiplier `datab`.
- `mult_clken` out 1: to multiplier `clken`.
- `mult_sclr` out 1: to multiplier `sclr`.
- `mult_result` in `2*WIDTH+2`: from multiplier `result`.

## Operation
- **Requester state.** Each requester has a `busy[i]` bit. At most one operation per requester is in flight.
- **Eligibility.** Requester i is eligible when `req_valid[i] & ~busy[i]`.
- **Arbitration.**
  - Round-robin among eligible requesters, starting at `rr_ptr`.
  - At most one grant per cycle.
  - `req_ready` is combinational from `req_valid`, `busy` and `rr_ptr`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- **Handshake with requester g.**
  - `busy[g]` is set.
  - `rr_ptr` becomes `(g+1) mod NREQ`.
  - The operands are driven to the multiplier in the same cycle.
  - A shadow pipeline entry {valid=1, id=g, hi=(op!=MUL)} enters stage 0.
- **Operand extension** to `WIDTH+1` bits:
  - A is sign-extended for MUL, MULH and MULHSU, and zero-extended for MULHU.
  - B is sign-extended for MUL and MULH, and zero-extended for MULHSU and MULHU.
- **Idle operands.** With no grant, `mult_dataa = mult_datab = 0` and the shadow entry has valid=0.
- **Result select.**
  - hi=0: `mult_result[WIDTH-1:0]`.
  - hi=1: `mult_result[2*WIDTH-1:WIDTH]`.
  - The top 2 bits are discarded.
- **Shadow pipeline.** `LATENCY` stages that shift every cycle. There is no stall; `mult_clken` is tied to 1 out of reset.
- **Response.**
  - When the last shadow stage is valid with id g, the next cycle gives `rsp_valid[g]=1`, `rsp_result` = the selected bits (registered), and `busy[g]` cleared.
  - Requester g is eligible again in that same `rsp_valid` cycle.
- **Reset.**
  - While `reset_n=0`: `mult_sclr=1`, all shadow valids cleared, `busy=0`, `rr_ptr=0`.
  - In-flight operations are dropped silently; no `rsp_valid` follows.
  - `mult_sclr=0` otherwise.
- **Reset values:** `req_ready=0`, `rsp_valid=0`, `rsp_result=0`, `mult_dataa=0`, `mult_datab=0`, `mult_clken=1`, `mult_sclr=1`.

## Timing
- **Throughput.** One issue per cycle in aggregate, one in flight per requester.
- **Latency.** Handshake in cycle T gives `rsp_valid` in cycle T+LATENCY+1.
- **Response collisions.** Responses never collide: issues are serialized, so at most one result retires per cycle.
- **Back-to-back issue.** If requester g has a response in cycle T and `req_valid[g]` is high, g may be granted in cycle T, subject to round-robin order.
- **Boundary cases.**
  - All requesters busy: `req_ready=0`, shadow stage 0 invalid.
  - `rr_ptr` wraps from `NREQ-1` to 0.
  - A reset deasserting in cycle T allows a first grant in cycle T+1.

## Structure
- Package `mult_sched_pkg`:
  - `mult_op_t` enum (`OP_MUL`, `OP_MULH`, `OP_MULHSU`, `OP_MULHU`).
  - Shadow-entry struct `{valid, id, hi}` with `id` width `$clog2(NREQ)`.
  - Function `ext_operand(value, signed)`.
- Sub-module `rr_arbiter` (parameter N).
  - Ports: `req[N]`, `ptr`, `grant[N]` (one-hot), `grant_id`, `any`.
  - Purely combinational, and reused by other shared-unit schedulers.
- The multiplier is instantiated by the parent, not inside `mult_sched`.

## Test plan
All scenarios use NREQ=4, WIDTH=32, LATENCY=3, and a bench-instantiated signed `lpm_mult`.
- **Single MUL.** Req0 MUL a=7, b=-3 handshaked at T → `rsp_valid=4'b0001` at T+4, `rsp_result=0xFFFFFFEB`.
- **High-half ops.** With a=b=0x80000000:
  - Req1 MULH → `0x40000000`.
  - MULHU → `0x40000000`.
  - MULHSU → `0xC0000000`.
  - MUL → `0x00000000`.
- **Round-robin.** All four requesters valid continuously → grants in order 0,1,2,3, then each re-granted in the same cycle its `rsp_valid` pulses.
- **Busy blocking.** Req2 valid continuously with only one in flight → `req_ready[2]` low for cycles T+1..T+3 and high again at T+4.
- **Reset mid-flight.** `reset_n` low for one cycle at T+2 after a req3 issue at T → no `rsp_valid` ever; `mult_sclr=1` that cycle; `req_ready[3]` grantable at T+3.
- **Idle.** No `req_valid` for 10 cycles → `mult_dataa=mult_datab=0`, `rsp_valid=0` throughout.
